// File: rtl/idli_sqi_ctl_m.sv
// SQI serial SRAM controller: issues command/address nibbles, handles dummy
// cycles, then streams data nibbles with a 2b sync counter and assembles
// 16b words for the instruction decoder.
module idli_sqi_ctl_m (
  input  logic             i_sq_gck,
  input  logic             i_sq_rst,
  input  logic             i_sq_redirect,
  input  logic             i_sq_wr,
  input  logic [15:0]      i_sq_addr,
  input  logic             i_sq_stop,
  input  logic [3:0]       i_sq_wdata,
  input  logic [3:0]       i_sq_sio,
  output logic [3:0]       o_sq_sio,
  output logic [3:0]       o_sq_sio_oe,
  output logic             o_sq_cs_n,
  output logic             o_sq_sck_en,
  output logic [1:0]       o_sq_ctr,
  output logic [3:0][3:0]  o_sq_enc,
  output logic             o_sq_valid
);

  localparam int unsigned CNT_W     = 3;
  localparam int unsigned ADDR_LAST = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CMD,
    ADDR,
    DUMMY,
    DATA
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      addr_q;
  logic             wr_q;
  logic [3:0]       sio_q;

  // Nibble idx (0 = most significant) of the 24b byte address for word addr a.
  function automatic logic [3:0] addr_nib(input logic [15:0] a, input logic [CNT_W-1:0] idx);
    logic [23:0] b;
    b = {7'b0, a, 1'b0} << {idx, 2'b00};
    return b[23:20];
  endfunction

  // Sequencer: state, phase counter and all registered pin/decoder outputs.
  always_ff @(posedge i_sq_gck or posedge i_sq_rst) begin
    if (i_sq_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      sio_q       <= 4'h0;
      o_sq_sio_oe <= 4'h0;
      o_sq_cs_n   <= 1'b1;
      o_sq_sck_en <= 1'b0;
      o_sq_ctr    <= 2'd3;
      o_sq_enc    <= '0;
      o_sq_valid  <= 1'b0;
    end else if (i_sq_redirect) begin
      // A redirect always restarts through a deselect cycle.
      state       <= START;
      cnt         <= '0;
      addr_q      <= i_sq_addr;
      wr_q        <= i_sq_wr;
      sio_q       <= 4'h0;
      o_sq_sio_oe <= 4'h0;
      o_sq_cs_n   <= 1'b1;
      o_sq_sck_en <= 1'b0;
      o_sq_ctr    <= 2'd3;
      o_sq_valid  <= 1'b0;
    end else if (i_sq_stop && (state != IDLE)) begin
      state       <= IDLE;
      cnt         <= '0;
      sio_q       <= 4'h0;
      o_sq_sio_oe <= 4'h0;
      o_sq_cs_n   <= 1'b1;
      o_sq_sck_en <= 1'b0;
      o_sq_ctr    <= 2'd3;
      o_sq_valid  <= 1'b0;
    end else begin
      case (state)
        START: begin
          state       <= CMD;
          cnt         <= '0;
          sio_q       <= 4'h0;
          o_sq_sio_oe <= 4'hF;
          o_sq_cs_n   <= 1'b0;
          o_sq_sck_en <= 1'b1;
        end
        CMD: begin
          if (cnt == '0) begin
            cnt   <= CNT_W'(1);
            sio_q <= wr_q ? 4'h2 : 4'h3;
          end else begin
            state <= ADDR;
            cnt   <= '0;
            sio_q <= addr_nib(addr_q, '0);
          end
        end
        ADDR: begin
          if (cnt != CNT_W'(ADDR_LAST)) begin
            cnt   <= cnt + CNT_W'(1);
            sio_q <= addr_nib(addr_q, cnt + CNT_W'(1));
          end else begin
            cnt   <= '0;
            sio_q <= 4'h0;
            if (wr_q) begin
              state       <= DATA;
              o_sq_sio_oe <= 4'hF;
            end else begin
              state       <= DUMMY;
              o_sq_sio_oe <= 4'h0;
            end
          end
        end
        DUMMY: begin
          if (cnt == '0) begin
            cnt <= CNT_W'(1);
          end else begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          o_sq_ctr <= o_sq_ctr + 2'd1;
          if (!wr_q) begin
            o_sq_enc[2'(o_sq_ctr + 2'd1)] <= i_sq_sio;
            o_sq_valid <= (o_sq_ctr == 2'd2);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write data passes straight to the pins; everything else is registered.
  always_comb begin
    o_sq_sio = sio_q;
    if ((state == DATA) && wr_q) begin
      o_sq_sio = i_sq_wdata;
    end
  end

endmodule

// File: doc/idli_sqi_ctl_m.md
# idli_sqi_ctl_m

SQI (quad-SPI) memory controller that sequences the external serial SRAM and produces the nibble stream, sync counter and assembled 16b encoding consumed by the instruction decoder and the execution units. Software-visible accesses (fetch, redirect, LD/ST traffic) arrive as a start-address plus direction. The block issues the command and address nibbles, handles dummy cycles, then streams data nibbles with a 2b counter. It is the producer end of the decoder's `ctr`/`enc` interface.

## Interface
- No parameters.
- `i_sq_gck` in 1: core clock; also the SQI bit clock, gated externally by `o_sq_sck_en`.
- `i_sq_rst` in 1: asynchronous, active-high reset.
- `i_sq_redirect` in 1: start a new access at `i_sq_addr`; sampled every cycle.
- `i_sq_wr` in 1: direction of the redirected access (1 = write); sampled with `i_sq_redirect`.
- `i_sq_addr` in 16: word address of the redirected access.
- `i_sq_stop` in 1: end the current access (deselect).
- `i_sq_wdata` in 4: write nibble, driven on SIO during write DATA cycles.
- `i_sq_sio` in 4: SIO pins in.
- `o_sq_sio` out 4: SIO pins out.
- `o_sq_sio_oe` out 4: SIO output enables.
- `o_sq_cs_n` out 1: chip select, active low.
- `o_sq_sck_en` out 1: SCK gate enable.
- `o_sq_ctr` out 2: nibble sync counter.
- `o_sq_enc` out 4x4: assembled word; `[0]` is the first nibble received (opcode).
- `o_sq_valid` out 1: `o_sq_enc` holds a complete word. Only asserted when `o_sq_ctr == 3`.

## Operation
- States: `IDLE`, `START`, `CMD`, `ADDR`, `DUMMY`, `DATA`.
- Redirect latches `addr_q`, `wr_q` and moves to `START` from any state, including `START`, where the latched values are replaced.
- `START` lasts 1 cycle: `cs_n = 1`, `oe = 0`. This guarantees a deselect edge between accesses.
- `CMD` lasts 2 cycles, `oe = 4'hF`. It drives the command byte high nibble first: READ `8'h03`, WRITE `8'h02`.
- `ADDR` lasts 6 cycles, `oe = 4'hF`. It drives the 24b byte address `{7'b0, addr_q, 1'b0}`, most-significant nibble first.
- `DUMMY` lasts 2 cycles, `oe = 0`, read only. Writes go from `ADDR` directly to `DATA`.
- `DATA` runs until stop or redirect.
  - Read: `oe = 0`; `i_sq_sio` is sampled at each posedge.
  - Write: `oe = 4'hF`; `o_sq_sio = i_sq_wdata`, combinational.
- In every state except `IDLE` and `START`: `cs_n = 0` and `sck_en = 1`.
- Counter:
  - Outside `DATA`, `o_sq_ctr` is forced to 3 and `o_sq_valid` to 0.
  - Each `DATA` cycle, ctr increments (wrapping 3→0).
  - On a read, the sampled nibble is written to `o_sq_enc[(ctr+1) mod 4]`.
  - `o_sq_valid` is set on the first ctr 2→3 transition inside `DATA` and is 1 in every later ctr==3 read cycle. It is never set for writes.
- Stop moves to `IDLE` next cycle: `cs_n = 1`, ctr = 3, valid = 0. `o_sq_enc` is retained.
- Redirect and stop in the same cycle: redirect wins.
- Stop while in `IDLE` is ignored. Stop in `CMD`, `ADDR` or `DUMMY` aborts to `IDLE`.
- Address wrap beyond the device is handled by the device's sequential mode; the block never increments the address itself.

## Timing
- Reset values:
  - state `IDLE`, `o_sq_cs_n = 1`, `o_sq_sck_en = 0`
  - `o_sq_sio = 0`, `o_sq_sio_oe = 0`
  - `o_sq_ctr = 3`, `o_sq_valid = 0`, `o_sq_enc` all zero
  - `addr_q = 0`, `wr_q = 0`
- Reset asserted mid-access returns every output to its reset value immediately (asynchronous). Operation resumes only on a new redirect.
- Read latency, with the redirect sampled at the end of cycle 0:
  - cycle 1 `START`; cycles 2–3 `CMD`; cycles 4–9 `ADDR`; cycles 10–11 `DUMMY`; cycles 12–15 capture `enc[0..3]`.
  - Cycle 16: `ctr = 3`, `valid = 1`, first word complete. A new word completes every 4 cycles after that.
- Write latency: first write nibble is on the pins in cycle 10 with `ctr = 3`. Nibble `k` of each word is driven while ctr == (k+3) mod 4.
- All outputs are registered except `o_sq_sio` in write `DATA`.
- Consumers flop `o_sq_enc` at the posedge ending a ctr==3 cycle, before `enc[0]` is overwritten.

## Test plan
- Read of word 0x1234 at addr 0x0040:
  - Pins show `0,3` then `0,0,0,0,8,0`.
  - Two hi-Z dummy cycles follow, then SIO 1,2,3,4 is sampled.
  - Cycle 16: `enc = {1,2,3,4}`, ctr = 3, valid = 1.
- Streaming read of 3 words: valid pulses exactly in cycles 16, 20 and 24. `enc` is correct at each pulse, and ctr wraps 3,0,1,2 with no gaps.
- Write to addr 0xFFFF:
  - Command nibbles 0,2; address nibbles `0,1,F,F,F,E`.
  - `wdata` A,B,C,D appears on pins in cycles 10–13 with oe = F; valid stays 0.
- Redirect in cycle 7 of a read (mid-`ADDR`): cs_n goes high in cycle 8 and the command restarts in cycle 9. Redirect+stop together: redirect wins.
- Stop in `DATA` while ctr = 1: `IDLE` next cycle with cs_n = 1, ctr = 3, valid = 0, and `enc` held.
- Reset asserted asynchronously mid-`DATA`: all outputs reach their reset values before the next clock edge. A redirect afterwards gives the normal 16-cycle latency.
